// File: rtl/cla_multiword_seq.sv
//------------------------------------------------------------------------------
// Module   : cla_multiword_seq (with leaf CLA_16bit)
// Brief    : Wide add/subtract by reusing one 16-bit CLA over WORDS words,
//            LSW first, with the inter-word carry held in a register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module CLA_16bit (
    output logic        c_out,
    output logic [15:0] Sum,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_In
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;

    assign w_g = A & B;
    assign w_p = A ^ B;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_grp
            logic [3:0] w_gl;
            logic [3:0] w_pl;
            logic [3:0] w_cl;
            assign w_gl = w_g[4*k +: 4];
            assign w_pl = w_p[4*k +: 4];
            assign w_cl[0] = w_gc[k];
            assign w_cl[1] = w_gl[0] | (w_pl[0] & w_gc[k]);
            assign w_cl[2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_gc[k]);
            assign w_cl[3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                           | (w_pl[2] & w_pl[1] & w_pl[0] & w_gc[k]);
            assign Sum[4*k +: 4] = w_pl ^ w_cl;
            assign w_gg[k] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                           | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
            assign w_gp[k] = &w_pl;
        end
    endgenerate

    // Second-level lookahead across the four 4-bit groups
    assign w_gc[0] = C_In;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & C_In);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & C_In);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & C_In);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & C_In);
    assign c_out = w_gc[4];
endmodule

module cla_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   sum,
    output logic                  c_out,
    output logic                  ovf
);
    localparam int                c_W    = 16 * WORDS;
    localparam int                c_IW   = $clog2(WORDS);
    localparam logic [c_IW-1:0]   c_LAST = c_IW'(WORDS - 1);
    localparam logic [1:0]        c_IDLE = 2'd0;
    localparam logic [1:0]        c_RUN  = 2'd1;
    localparam logic [1:0]        c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_W-1:0]   r_a;
    logic [c_W-1:0]   r_b;
    logic [c_W-1:0]   r_sum;
    logic             r_carry;
    logic [c_IW-1:0]  r_idx;
    logic             r_cout;
    logic             r_ovf;
    logic [15:0]      w_cla_sum;
    logic             w_cla_cout;
    logic             w_accept;
    logic             w_last;

    CLA_16bit u_cla (
        .c_out (w_cla_cout),
        .Sum   (w_cla_sum),
        .A     (r_a[{r_idx, 4'b0000} +: 16]),
        .B     (r_b[{r_idx, 4'b0000} +: 16]),
        .C_In  (r_carry)
    );

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_last   = (r_state == c_RUN) && (r_idx == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (r_idx == c_LAST) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Subtract is A + ~B + 1, so the inversion and the +1 are folded in at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub ? 1'b1 : c_in;
            r_idx   <= '0;
        end else if (r_state == c_RUN) begin
            r_sum[{r_idx, 4'b0000} +: 16] <= w_cla_sum;
            r_carry <= w_cla_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cla_cout;
                r_ovf  <= (r_a[c_W-1] == r_b[c_W-1]) && (w_cla_sum[15] != r_a[c_W-1]);
            end
        end
    end

    assign busy  = (r_state != c_IDLE);
    assign done  = (r_state == c_DONE);
    assign sum   = r_sum;
    assign c_out = r_cout;
    assign ovf   = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_cla_multiword_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_cla_multiword_seq
// Brief    : Directed and random self-checking bench for cla_multiword_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cla_multiword_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         op_sub = 1'b0;
    logic         c_in   = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int  checks   = 0;
    int  failures = 0;
    time t_done   = 0;
    time t_prev   = 0;

    cla_multiword_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic ref_model(input logic [63:0] ra, input logic [63:0] rb, input logic rop,
                             input logic rcin, output logic [63:0] s, output logic c,
                             output logic v);
        logic [63:0] bb;
        logic [64:0] t;
        bb = rop ? ~rb : rb;
        t  = {1'b0, ra} + {1'b0, bb} + {64'd0, (rop ? 1'b1 : rcin)};
        s  = t[63:0];
        c  = t[64];
        v  = (ra[63] == bb[63]) && (t[63] != ra[63]);
    endtask

    // Drive a request for one cycle, then scramble inputs to prove they were latched
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic iop,
                         input logic icin);
        @(negedge clk);
        a = ia; b = ib; op_sub = iop; c_in = icin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ia; b = ~ib; op_sub = ~iop; c_in = ~icin;
    endtask

    task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                          input logic iop, input logic icin, input logic [63:0] es,
                          input logic ec, input logic ev);
        int lat;
        int nbusy;
        issue(ia, ib, iop, icin);
        lat = 0;
        nbusy = 0;
        forever begin
            if (busy) nbusy++;
            lat++;
            if (done) begin
                t_done = $time;
                break;
            end
            if (lat >= 20) break;
            @(posedge clk);
            #1;
        end
        check({tag, " latency"}, 64'(lat), 64'd5);
        check({tag, " busy_cycles"}, 64'(nbusy), 64'd5);
        check({tag, " sum"}, sum, es);
        check({tag, " c_out"}, {63'd0, c_out}, {63'd0, ec});
        check({tag, " ovf"}, {63'd0, ovf}, {63'd0, ev});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, " busy_low"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb, rs;
        logic        rop, rcin, rc, rv;
        int          ndone;
        logic [63:0] sum_at_done;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst sum", sum, 64'd0);
        check("rst c_out", {63'd0, c_out}, 64'd0);
        check("rst ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op("sub_5_3", 64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0);
        run_op("cin", 64'h0001_0000_0000_8000, 64'h0000_0000_0000_8000, 1'b0, 1'b1,
               64'h0001_0000_0001_0001, 1'b0, 1'b0);

        // Ignored start two cycles into a run
        issue(64'h0001_0000_0000_8000, 64'h0000_0000_0000_8000, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; op_sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        sum_at_done = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                sum_at_done = sum;
            end
            @(posedge clk);
            #1;
        end
        check("ign ndone", 64'(ndone), 64'd1);
        check("ign sum_at_done", sum_at_done, 64'h0001_0000_0001_0001);
        check("ign sum_hold", sum, 64'h0001_0000_0001_0001);
        check("ign busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-operation
        issue(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {63'd0, busy}, 64'd0);
        check("midrst sum", sum, 64'd0);
        check("midrst done", {63'd0, done}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst no_done", 64'(ndone), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0,
               64'h7, 1'b0, 1'b0);

        // Back-to-back random traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rop  = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rop, rcin, rs, rc, rv);
            t_prev = t_done;
            run_op("rand", ra, rb, rop, rcin, rs, rc, rv);
            if (n > 0) check("rand spacing", 64'(t_done - t_prev), 64'd60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
